exe_mem_wb_stage: RTL

Back half of the five-stage MIPS pipeline. Consumes the ID/EXE pipeline register outputs produced by `DataPath` (`ewreg`, `em2reg`, `ewmem`, `ealuc`, `ealuimm`, `edestReg`, `eqa`, `eqb`, `eimm32`). It runs the EXE-stage ALU, registers the result into EXE/MEM, performs the MEM-stage data-memory access, registers that into MEM/WB, and presents the write-back value and destination to the register file.

---
 rtl/exe_mem_wb_stage.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/exe_mem_wb_stage.sv
// rtl/exe_mem_wb_stage.sv - EXE, MEM and WB back half of a five-stage MIPS pipeline
//
// Purpose: runs the EXE-stage ALU on ID/EXE operands, registers the result into
// EXE/MEM, performs the data-memory access, registers that into MEM/WB and
// presents the write-back value and destination to the register file.
//
// Optional feature macro: DMEM_PRELOAD_EN
//   defined   - reset loads words 0..4 with fixed patterns, all others zero
//   undefined - reset clears every memory word
//
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   ewreg, em2reg, ewmem            EXE-stage control (reg write, load select, mem write)
//   ealuc[3:0], ealuimm             ALU op code, B-operand select (1 = eimm32)
//   edestReg[4:0]                   EXE destination register
//   eqa, eqb, eimm32 [31:0]         operand A, operand B / store data, immediate
//   mwreg, mm2reg, mwmem            EXE/MEM control
//   mdestReg[4:0], mr, mqb          EXE/MEM destination, ALU result, store data
//   wwreg, wm2reg                   MEM/WB control
//   wdestReg[4:0], wr, wdo          MEM/WB destination, ALU result, load data
//   wbData[31:0]                    write-back value (wm2reg ? wdo : wr)

module exe_mem_wb_stage #(
    parameter int DMEM_WORDS = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ewreg,
    input  logic        em2reg,
    input  logic        ewmem,
    input  logic [3:0]  ealuc,
    input  logic        ealuimm,
    input  logic [4:0]  edestReg,
    input  logic [31:0] eqa,
    input  logic [31:0] eqb,
    input  logic [31:0] eimm32,
    output logic        mwreg,
    output logic        mm2reg,
    output logic        mwmem,
    output logic [4:0]  mdestReg,
    output logic [31:0] mr,
    output logic [31:0] mqb,
    output logic        wwreg,
    output logic        wm2reg,
    output logic [4:0]  wdestReg,
    output logic [31:0] wr,
    output logic [31:0] wdo,
    output logic [31:0] wbData
);

    localparam int AW = $clog2(DMEM_WORDS);

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_NOR = 4'b1100;

    // Contents a memory word takes on reset.
    function automatic logic [31:0] init_word(input int idx);
        logic [31:0] w;
        w = 32'h0;
`ifdef DMEM_PRELOAD_EN
        case (idx)
            0:       w = 32'hA00000AA;
            1:       w = 32'h10000011;
            2:       w = 32'h20000022;
            3:       w = 32'h30000033;
            4:       w = 32'h40000044;
            default: w = 32'h0;
        endcase
`else
        if (idx < 0) w = 32'h0;
`endif
        return w;
    endfunction

    // ---------------- EXE: ALU ----------------
    logic [31:0] alu_b;
    logic [31:0] alu_r;

    always_comb begin
        alu_b = ealuimm ? eimm32 : eqb;
        alu_r = 32'h0;
        case (ealuc)
            ALU_AND: alu_r = eqa & alu_b;
            ALU_OR:  alu_r = eqa | alu_b;
            ALU_ADD: alu_r = eqa + alu_b;
            ALU_SUB: alu_r = eqa - alu_b;
            ALU_SLT: alu_r = {31'h0, $signed(eqa) < $signed(alu_b)};
            ALU_NOR: alu_r = ~(eqa | alu_b);
            default: alu_r = 32'h0;
        endcase
    end

    // ---------------- EXE/MEM register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mwreg    <= 1'b0;
            mm2reg   <= 1'b0;
            mwmem    <= 1'b0;
            mdestReg <= 5'h0;
            mr       <= 32'h0;
            mqb      <= 32'h0;
        end else begin
            mwreg    <= ewreg;
            mm2reg   <= em2reg;
            mwmem    <= ewmem;
            mdestReg <= edestReg;
            mr       <= alu_r;
            mqb      <= eqb;
        end
    end

    // ---------------- MEM: data memory ----------------
    // Byte-offset bits and bits above the array size are dropped, so any
    // address is legal and wraps modulo the memory size.
    logic [31:0]   mem [DMEM_WORDS];
    logic [AW-1:0] mem_idx;
    logic [31:0]   dout;

    assign mem_idx = mr[AW+1:2];
    assign dout    = mem[mem_idx];

    // Reset restores the power-on image, so stored data does not survive reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DMEM_WORDS; i++) begin
                mem[i] <= init_word(i);
            end
        end else if (mwmem) begin
            mem[mem_idx] <= mqb;
        end
    end

    // ---------------- MEM/WB register ----------------
    // wdo samples the combinational read, i.e. the word as it was before any
    // write committing on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wwreg    <= 1'b0;
            wm2reg   <= 1'b0;
            wdestReg <= 5'h0;
            wr       <= 32'h0;
            wdo      <= 32'h0;
        end else begin
            wwreg    <= mwreg;
            wm2reg   <= mm2reg;
            wdestReg <= mdestReg;
            wr       <= mr;
            wdo      <= dout;
        end
    end

    // ---------------- WB ----------------
    assign wbData = wm2reg ? wdo : wr;

endmodule
